// File: rtl/disp_scan_pkg.sv
// Shared types for the 8-digit display scanner.
// The DISP_SCAN_DP_EN macro adds a per-digit decimal-point field to the frame buffer.
package disp_scan_pkg;

  localparam int NDIG  = 8;
  localparam int SEL_W = 3;

  typedef logic [3:0]       nibble_t;
  typedef nibble_t [NDIG-1:0] digits_t;
  typedef logic [NDIG-1:0]  digmask_t;
  typedef logic [SEL_W-1:0] sel_t;

  // One complete frame's worth of display content, held as a single word.
  typedef struct packed {
    digits_t  data;
    digmask_t en;
`ifdef DISP_SCAN_DP_EN
    digmask_t dp;
`endif
  } frame_buf_t;

  localparam sel_t LAST_SEL = sel_t'(NDIG - 1);

  function automatic nibble_t digit_of(input digits_t d, input sel_t s);
    return d[s];
  endfunction

endpackage

// File: rtl/display_scan_prescaler.sv
// Prescaler for the display scanner: counts 0..DIV-1 and flags the terminal count.
// With DIV = 1 the tick is asserted every cycle.
module scan_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("scan_prescaler: DIV must be >= 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 8-digit hex display scanner with double-buffered, tear-free updates.
// Defining DISP_SCAN_DP_EN adds the dp input and dp_out output with buffered decimal points.
module display_scan
  import disp_scan_pkg::*;
#(
  parameter int DIV  = 100000,
  parameter int NDIG = disp_scan_pkg::NDIG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic        load,
`ifdef DISP_SCAN_DP_EN
  input  logic [7:0]  dp,
  output logic        dp_out,
`endif
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame_start,
  output logic        pending
);

  if (NDIG != 8) begin : g_bad_ndig
    $error("display_scan: NDIG is tied to the 3-bit select and must be 8");
  end

  logic tick;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  frame_buf_t active_q, active_d;
  frame_buf_t buf_q, buf_d;
  frame_buf_t load_val;
  sel_t       sel_q, sel_d;
  nibble_t    nibble_q, nibble_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic       pending_q, pending_d;
  logic       boundary;
`ifdef DISP_SCAN_DP_EN
  logic       dp_out_q, dp_out_d;
`endif

  always_comb begin
    load_val.data = digits_t'(data);
    load_val.en   = digmask_t'(digit_en);
`ifdef DISP_SCAN_DP_EN
    load_val.dp   = digmask_t'(dp);
`endif
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_d         = sel_q;
    active_d      = active_q;
    buf_d         = buf_q;
    pending_d     = pending_q;
    nibble_d      = nibble_q;
    blank_d       = blank_q;
`ifdef DISP_SCAN_DP_EN
    dp_out_d      = dp_out_q;
`endif
    boundary      = tick && (sel_q == LAST_SEL);
    frame_start_d = boundary;

    if (tick) sel_d = sel_q + 1'b1;

    // The transfer reads buf_q, so a load on the boundary edge lands in the next frame.
    if (boundary && pending_q) begin
      active_d  = buf_q;
      pending_d = 1'b0;
    end

    if (load) begin
      buf_d     = load_val;
      pending_d = 1'b1;
    end

    // Digit outputs track the new select, using the post-transfer active content.
    if (tick) begin
      nibble_d = digit_of(active_d.data, sel_d);
      blank_d  = ~active_d.en[sel_d];
`ifdef DISP_SCAN_DP_EN
      dp_out_d = active_d.dp[sel_d] & active_d.en[sel_d];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= '0;
      active_q      <= '0;
      buf_q         <= '0;
      pending_q     <= 1'b0;
      nibble_q      <= '0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef DISP_SCAN_DP_EN
      dp_out_q      <= 1'b0;
`endif
    end else begin
      sel_q         <= sel_d;
      active_q      <= active_d;
      buf_q         <= buf_d;
      pending_q     <= pending_d;
      nibble_q      <= nibble_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
`ifdef DISP_SCAN_DP_EN
      dp_out_q      <= dp_out_d;
`endif
    end
  end

  assign sel         = sel_q;
  assign nibble      = nibble_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;
`ifdef DISP_SCAN_DP_EN
  assign dp_out      = dp_out_q;
`endif

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIV = 4 (one frame = 32 cycles).
// Decimal-point checks are active when DISP_SCAN_DP_EN is defined.
module tb_display_scan;

  localparam int DIV  = 4;
  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic        load;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_start;
  logic        pending;
`ifdef DISP_SCAN_DP_EN
  logic [7:0]  dp;
  logic        dp_out;
  logic [7:0]  exp_dp;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_scan #(.DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .digit_en    (digit_en),
    .load        (load),
`ifdef DISP_SCAN_DP_EN
    .dp          (dp),
    .dp_out      (dp_out),
`endif
    .sel         (sel),
    .nibble      (nibble),
    .blank       (blank),
    .frame_start (frame_start),
    .pending     (pending)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge before sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_start();
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step(1);
      if (frame_start === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL frame_start_timeout: observed=none expected=pulse within 64 cycles");
    end
  endtask

  // Checks one full frame starting on its frame_start sample; optional loads at sample
  // indices ia/ib (index 31 is the boundary edge). Ends on the next frame_start sample.
  task automatic check_frame(input logic [31:0] exp_data, input logic [7:0] exp_en,
                             input int ia, input logic [31:0] da, input logic [7:0] ea,
                             input int ib, input logic [31:0] db, input logic [7:0] eb);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        int idx;
        idx = k * 4 + j;
        check($sformatf("sel[%0d.%0d]", k, j), {29'd0, sel}, k);
        check($sformatf("nibble[%0d.%0d]", k, j), {28'd0, nibble}, {28'd0, exp_data[4*k +: 4]});
        check($sformatf("blank[%0d.%0d]", k, j), {31'd0, blank}, {31'd0, ~exp_en[k]});
        check($sformatf("frame_start[%0d.%0d]", k, j), {31'd0, frame_start}, {31'd0, idx == 0});
`ifdef DISP_SCAN_DP_EN
        check($sformatf("dp_out[%0d.%0d]", k, j), {31'd0, dp_out}, {31'd0, exp_dp[k] & exp_en[k]});
`endif
        if (idx == ia) begin
          data = da; digit_en = ea; load = 1'b1;
        end else if (idx == ib) begin
          data = db; digit_en = eb; load = 1'b1;
        end
        step(1);
        load = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; digit_en = '0;
`ifdef DISP_SCAN_DP_EN
    dp = 8'h00; exp_dp = 8'h00;
`endif
    step(2);
    check("rst_sel", {29'd0, sel}, 0);
    check("rst_blank", {31'd0, blank}, 1);
    check("rst_nibble", {28'd0, nibble}, 0);
    check("rst_pending", {31'd0, pending}, 0);
    check("rst_frame_start", {31'd0, frame_start}, 0);

    rst = 1'b0;
    step(3);
    check("post_rst_sel_hold", {29'd0, sel}, 0);
    step(1);
    check("post_rst_sel_adv", {29'd0, sel}, 1);

    wait_frame_start();
    check("f0_pending", {31'd0, pending}, 0);

    // Basic display: load at sel 0, visible from the next frame_start.
    data = 32'h76543210; digit_en = 8'hFF; load = 1'b1;
    step(1);
    load = 1'b0;
    check("basic_pending_set", {31'd0, pending}, 1);
    check("basic_old_blank", {31'd0, blank}, 1);
    wait_frame_start();
    check("basic_pending_clr", {31'd0, pending}, 0);
    check_frame(32'h76543210, 8'hFF, NONE, '0, '0, NONE, '0, '0);

    // Tear-free: load at sel 3 does not disturb the current frame.
    check_frame(32'h76543210, 8'hFF, 12, 32'hFEDCBA98, 8'hFF, NONE, '0, '0);
    check("tear_pending_clr", {31'd0, pending}, 0);
    check_frame(32'hFEDCBA98, 8'hFF, 0, 32'h76543210, 8'h05, NONE, '0, '0);

    // Enable mask, plus load A at sel 2 and load B on the boundary edge.
    check_frame(32'h76543210, 8'h05, 8, 32'h13579BDF, 8'hFF, 31, 32'h2468ACE0, 8'hF0);
    check("collide_pending_kept", {31'd0, pending}, 1);
    check_frame(32'h13579BDF, 8'hFF, NONE, '0, '0, NONE, '0, '0);
    check("collide_pending_clr", {31'd0, pending}, 0);

    // Decimal points: 0x81 with all digits on, then digit 7 disabled.
`ifdef DISP_SCAN_DP_EN
    dp = 8'h81;
`endif
    check_frame(32'h2468ACE0, 8'hF0, 0, 32'h76543210, 8'hFF, NONE, '0, '0);
`ifdef DISP_SCAN_DP_EN
    exp_dp = 8'h81;
`endif
    check_frame(32'h76543210, 8'hFF, 0, 32'h76543210, 8'h7F, NONE, '0, '0);
    check_frame(32'h76543210, 8'h7F, NONE, '0, '0, NONE, '0, '0);

    // Reset mid-frame with a load pending: everything clears and the load is lost.
    step(9);
    check("pre_rst_nibble", {28'd0, nibble}, 2);
    data = 32'hFFFFFFFF; digit_en = 8'hFF; load = 1'b1;
    step(1);
    load = 1'b0;
    check("pre_rst_pending", {31'd0, pending}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", {29'd0, sel}, 0);
    check("mid_rst_blank", {31'd0, blank}, 1);
    check("mid_rst_nibble", {28'd0, nibble}, 0);
    check("mid_rst_pending", {31'd0, pending}, 0);
    check("mid_rst_frame_start", {31'd0, frame_start}, 0);
`ifdef DISP_SCAN_DP_EN
    check("mid_rst_dp_out", {31'd0, dp_out}, 0);
`endif
    rst = 1'b0;
    step(3);
    check("rel_sel_hold", {29'd0, sel}, 0);
    step(1);
    check("rel_sel_adv", {29'd0, sel}, 1);
    check("rel_blank", {31'd0, blank}, 1);
    wait_frame_start();
    check("discard_blank", {31'd0, blank}, 1);
    check("discard_nibble", {28'd0, nibble}, 0);
    check("discard_pending", {31'd0, pending}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
